// File: rtl/jet_argmax.sv
// jet_argmax: sequential arg-max over NCLASS signed logits.
// Captures one vector, compares one logit per cycle against the running best,
// and presents the class index, the winning value and a tie flag with a
// valid/ready handshake. The lowest index wins on equal values.
module jet_argmax #(
   parameter int WIDTH  = 25,
   parameter int NFRAC  = 12,
   parameter int NCLASS = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NCLASS*WIDTH-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2:0]                out_class,
   output logic [WIDTH-1:0]          out_max,
   output logic                      out_tie,
   output logic [15:0]               out_count
);

   // Index of the final logit; the SCAN edge that handles it moves to DONE.
   localparam logic [2:0] LAST_IDX = 3'(NCLASS - 1);

   // The fraction width only matters to whoever interprets out_max.
   // Reject configurations that make no sense at elaboration time.
   if (NCLASS < 2 || NCLASS > 8 || NFRAC < 0 || NFRAC >= WIDTH) begin : g_bad_param
      $error("jet_argmax: illegal NCLASS/NFRAC/WIDTH combination");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [NCLASS*WIDTH-1:0]   logits_q, logits_d;
   logic [2:0]                ptr_q, ptr_d;
   logic [2:0]                idx_q, idx_d;
   logic signed [WIDTH-1:0]   best_q, best_d;
   logic                      tie_q, tie_d;

   logic                      out_valid_q;
   logic [2:0]                out_class_q, out_class_d;
   logic [WIDTH-1:0]          out_max_q, out_max_d;
   logic                      out_tie_q, out_tie_d;
   logic [15:0]               out_count_q, out_count_d;

   logic signed [WIDTH-1:0]   lg_s [8];
   logic signed [WIDTH-1:0]   cur_s;
   logic signed [WIDTH-1:0]   first_s;
   logic                      accept_s;
   logic                      scan_s;
   logic                      deliver_s;
   logic                      last_s;
   logic                      gt_s;
   logic                      eq_s;

   // Unpacked view of the captured vector; unused slots read as zero.
   for (genvar g = 0; g < 8; g++) begin : g_unpack
      if (g < NCLASS) begin : g_real
         assign lg_s[g] = logits_q[g*WIDTH +: WIDTH];
      end else begin : g_pad
         assign lg_s[g] = {WIDTH{1'b0}};
      end
   end

   assign first_s   = in_data[WIDTH-1:0];
   assign cur_s     = lg_s[ptr_q];
   assign gt_s      = (cur_s > best_q);
   assign eq_s      = (cur_s == best_q);
   assign last_s    = (ptr_q == LAST_IDX);
   assign scan_s    = (state_q == S_SCAN);
   assign deliver_s = (state_q == S_DONE) && out_ready;
   assign accept_s  = in_valid && in_ready;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: DONE can hand straight over to a new SCAN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) state_d = S_SCAN;
            else          state_d = S_IDLE;
         end
         S_SCAN: begin
            if (last_s) state_d = S_DONE;
            else        state_d = S_SCAN;
         end
         S_DONE: begin
            if (!out_ready)    state_d = S_DONE;
            else if (in_valid) state_d = S_SCAN;
            else               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: ready when idle, or when the held result is leaving.
   always_comb begin
      in_ready = 1'b0;
      if (reset) begin
         in_ready = 1'b0;
      end else begin
         case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_DONE:  in_ready = out_ready;
            default: in_ready = 1'b0;
         endcase
      end
   end

   // Datapath next values: capture on accept, one compare per SCAN cycle.
   always_comb begin
      logits_d    = logits_q;
      ptr_d       = ptr_q;
      idx_d       = idx_q;
      best_d      = best_q;
      tie_d       = tie_q;
      out_class_d = out_class_q;
      out_max_d   = out_max_q;
      out_tie_d   = out_tie_q;
      out_count_d = out_count_q;

      if (accept_s) begin
         logits_d = in_data;
         best_d   = first_s;
         idx_d    = 3'd0;
         tie_d    = 1'b0;
         ptr_d    = 3'd1;
      end else if (scan_s) begin
         ptr_d = ptr_q + 3'd1;
         if (gt_s) begin
            best_d = cur_s;
            idx_d  = ptr_q;
            tie_d  = 1'b0;
         end else if (eq_s) begin
            tie_d  = 1'b1;
         end else begin
            tie_d  = tie_q;
         end
      end else begin
         ptr_d = ptr_q;
      end

      // Results are published on the edge that finishes the scan.
      if (scan_s && last_s) begin
         out_class_d = idx_d;
         out_max_d   = best_d;
         out_tie_d   = tie_d;
      end else begin
         out_class_d = out_class_q;
      end

      if (deliver_s && (out_count_q != 16'hFFFF)) begin
         out_count_d = out_count_q + 16'd1;
      end else begin
         out_count_d = out_count_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         logits_q <= {(NCLASS*WIDTH){1'b0}};
         ptr_q    <= 3'd0;
         idx_q    <= 3'd0;
         best_q   <= {WIDTH{1'b0}};
         tie_q    <= 1'b0;
      end else begin
         logits_q <= logits_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         best_q   <= best_d;
         tie_q    <= tie_d;
      end
   end

   // Registered result outputs and delivery counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_class_q <= 3'd0;
         out_max_q   <= {WIDTH{1'b0}};
         out_tie_q   <= 1'b0;
         out_count_q <= 16'd0;
      end else begin
         out_valid_q <= (state_d == S_DONE);
         out_class_q <= out_class_d;
         out_max_q   <= out_max_d;
         out_tie_q   <= out_tie_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_class = out_class_q;
   assign out_max   = out_max_q;
   assign out_tie   = out_tie_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_jet_argmax.sv
// Directed self-checking bench for jet_argmax (default parameters).
module tb_jet_argmax;

   localparam int W = 25;
   localparam int N = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [N*W-1:0]   in_data;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out_class;
   logic [W-1:0]     out_max;
   logic             out_tie;
   logic [15:0]      out_count;

   int n_cmp = 0;
   int n_bad = 0;

   jet_argmax #(.WIDTH(W), .NFRAC(12), .NCLASS(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_max   (out_max),
      .out_tie   (out_tie),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [N*W-1:0] pack5(input int a0, input int a1, input int a2,
                                            input int a3, input int a4);
      logic [N*W-1:0] v;
      v[0*W +: W] = a0[W-1:0];
      v[1*W +: W] = a1[W-1:0];
      v[2*W +: W] = a2[W-1:0];
      v[3*W +: W] = a3[W-1:0];
      v[4*W +: W] = a4[W-1:0];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a vector, wait for acceptance, then count edges until out_valid.
   task automatic run_vec(input logic [N*W-1:0] v, output int lat);
      int guard;
      in_data  = v;
      in_valid = 1'b1;
      #1;
      guard = 0;
      while (!in_ready && guard < 20) begin
         step();
         guard++;
      end
      step();
      in_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         if (!out_valid) begin
            step();
            lat = i;
         end
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      step();
      step();
      if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready: got %0b want 0", in_ready); n_bad++; end
      n_cmp++;
      if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %0b want 0", out_valid); n_bad++; end
      n_cmp++;
      if (out_class !== 3'd0 || out_max !== 25'd0 || out_tie !== 1'b0) begin
         $display("FAIL rst_result: got class %0d max %0h tie %0b want 0 0 0", out_class, out_max, out_tie);
         n_bad++;
      end
      n_cmp++;
      if (out_count !== 16'd0) begin $display("FAIL rst_count: got %0d want 0", out_count); n_bad++; end
      n_cmp++;
      reset = 1'b0;
      #1;
      if (in_ready !== 1'b1) begin $display("FAIL rst_release_ready: got %0b want 1", in_ready); n_bad++; end
      n_cmp++;
   endtask

   task automatic test_distinct();
      int lat;
      out_ready = 1'b1;
      run_vec(pack5(-255, -257, -288, 336, 882), lat);
      if (lat !== 4) begin $display("FAIL distinct_latency: got %0d want 4", lat); n_bad++; end
      n_cmp++;
      if (out_class !== 3'd4) begin $display("FAIL distinct_class: got %0d want 4", out_class); n_bad++; end
      n_cmp++;
      if (out_max !== 25'd882) begin $display("FAIL distinct_max: got %0h want %0h", out_max, 25'd882); n_bad++; end
      n_cmp++;
      if (out_tie !== 1'b0) begin $display("FAIL distinct_tie: got %0b want 0", out_tie); n_bad++; end
      n_cmp++;
      step();
      if (out_count !== 16'd1 || out_valid !== 1'b0) begin
         $display("FAIL distinct_deliver: got count %0d valid %0b want 1 0", out_count, out_valid);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_tie();
      int lat;
      out_ready = 1'b1;
      run_vec(pack5(100, 300, 300, -5, 300), lat);
      if (out_class !== 3'd1) begin $display("FAIL tie_class: got %0d want 1", out_class); n_bad++; end
      n_cmp++;
      if (out_max !== 25'd300) begin $display("FAIL tie_max: got %0h want %0h", out_max, 25'd300); n_bad++; end
      n_cmp++;
      if (out_tie !== 1'b1) begin $display("FAIL tie_flag: got %0b want 1", out_tie); n_bad++; end
      n_cmp++;
      step();
      if (out_count !== 16'd2) begin $display("FAIL tie_count: got %0d want 2", out_count); n_bad++; end
      n_cmp++;
   endtask

   task automatic test_negative();
      int lat;
      out_ready = 1'b1;
      run_vec(pack5(-16777216, -16777216, -1, -16777216, -16777216), lat);
      if (out_class !== 3'd2) begin $display("FAIL neg_class: got %0d want 2", out_class); n_bad++; end
      n_cmp++;
      if (out_max !== 25'h1FFFFFF) begin $display("FAIL neg_max: got %0h want 1ffffff", out_max); n_bad++; end
      n_cmp++;
      if (out_tie !== 1'b0) begin $display("FAIL neg_tie: got %0b want 0", out_tie); n_bad++; end
      n_cmp++;
      step();
      if (out_count !== 16'd3) begin $display("FAIL neg_count: got %0d want 3", out_count); n_bad++; end
      n_cmp++;
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready = 1'b0;
      in_data   = pack5(-255, -257, -288, 336, 882);
      in_valid  = 1'b1;
      #1;
      step();
      // second vector pending while the first one scans and waits
      in_data = pack5(100, 300, 300, -5, 300);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         if (!out_valid) begin
            step();
            lat = i;
         end
      end
      if (lat !== 4) begin $display("FAIL b2b_first_latency: got %0d want 4", lat); n_bad++; end
      n_cmp++;
      for (int c = 0; c < 10; c++) begin
         step();
         if (out_valid !== 1'b1 || out_class !== 3'd4 || out_max !== 25'd882 ||
             out_tie !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL b2b_hold cycle %0d: got valid %0b class %0d max %0h tie %0b ready %0b want 1 4 372 0 0",
                     c, out_valid, out_class, out_max, out_tie, in_ready);
            n_bad++;
         end
         n_cmp++;
      end
      if (out_count !== 16'd3) begin $display("FAIL b2b_count_held: got %0d want 3", out_count); n_bad++; end
      n_cmp++;
      out_ready = 1'b1;
      #1;
      if (in_ready !== 1'b1) begin $display("FAIL b2b_ready: got %0b want 1", in_ready); n_bad++; end
      n_cmp++;
      step();
      in_valid = 1'b0;
      if (out_count !== 16'd4 || out_valid !== 1'b0) begin
         $display("FAIL b2b_handover: got count %0d valid %0b want 4 0", out_count, out_valid);
         n_bad++;
      end
      n_cmp++;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         if (!out_valid) begin
            step();
            lat = i;
         end
      end
      if (lat !== 4) begin $display("FAIL b2b_second_latency: got %0d want 4", lat); n_bad++; end
      n_cmp++;
      if (out_class !== 3'd1 || out_max !== 25'd300 || out_tie !== 1'b1) begin
         $display("FAIL b2b_second_result: got class %0d max %0h tie %0b want 1 12c 1", out_class, out_max, out_tie);
         n_bad++;
      end
      n_cmp++;
      step();
      if (out_count !== 16'd5) begin $display("FAIL b2b_count: got %0d want 5", out_count); n_bad++; end
      n_cmp++;
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      int seen;
      out_ready = 1'b1;
      in_data   = pack5(-255, -257, -288, 336, 882);
      in_valid  = 1'b1;
      #1;
      step();
      in_valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      #1;
      if (out_valid !== 1'b0 || out_class !== 3'd0 || out_max !== 25'd0 ||
          out_tie !== 1'b0 || out_count !== 16'd0) begin
         $display("FAIL midrst_outputs: got valid %0b class %0d max %0h tie %0b count %0d want all 0",
                  out_valid, out_class, out_max, out_tie, out_count);
         n_bad++;
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin $display("FAIL midrst_ready: got %0b want 0", in_ready); n_bad++; end
      n_cmp++;
      step();
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) seen++;
      end
      if (seen !== 0) begin $display("FAIL midrst_no_valid: got %0d pulses want 0", seen); n_bad++; end
      n_cmp++;
      run_vec(pack5(5, -3, 7, 7, 0), lat);
      if (lat !== 4) begin $display("FAIL midrst_latency: got %0d want 4", lat); n_bad++; end
      n_cmp++;
      if (out_class !== 3'd2 || out_max !== 25'd7 || out_tie !== 1'b1) begin
         $display("FAIL midrst_result: got class %0d max %0h tie %0b want 2 7 1", out_class, out_max, out_tie);
         n_bad++;
      end
      n_cmp++;
      step();
      if (out_count !== 16'd1) begin $display("FAIL midrst_count: got %0d want 1", out_count); n_bad++; end
      n_cmp++;
   endtask

   task automatic test_count_sat();
      int lat;
      logic [15:0] exp_cnt [3];
      exp_cnt[0] = 16'hFFFE;
      exp_cnt[1] = 16'hFFFF;
      exp_cnt[2] = 16'hFFFF;
      out_ready = 1'b1;
      force dut.out_count_q = 16'hFFFD;
      step();
      release dut.out_count_q;
      #1;
      if (out_count !== 16'hFFFD) begin $display("FAIL sat_preload: got %0h want fffd", out_count); n_bad++; end
      n_cmp++;
      for (int k = 0; k < 3; k++) begin
         run_vec(pack5(1, 2, 3, 4, 5), lat);
         if (out_class !== 3'd4) begin $display("FAIL sat_class %0d: got %0d want 4", k, out_class); n_bad++; end
         n_cmp++;
         step();
         if (out_count !== exp_cnt[k]) begin
            $display("FAIL sat_count %0d: got %0h want %0h", k, out_count, exp_cnt[k]);
            n_bad++;
         end
         n_cmp++;
      end
   endtask

   initial begin
      test_reset();
      test_distinct();
      test_tie();
      test_negative();
      test_back_to_back();
      test_reset_mid_scan();
      test_count_sat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
